shift_driver: RTL and testbench
===============================

SHIFT_DRIVER -- requirements
Module: shift_driver

Interface
REQ-001 Parameter WIDTH, default 8, range 2..32: number of bits shifted per transfer.
REQ-002 clk  input  1  single clock; all flops rising-edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 load_valid  input  1  parallel word offered.
REQ-005 load_ready  output  1  block can accept a word.
REQ-006 load_data  input  WIDTH  word to shift out, LSB first.
REQ-007 scan_out  output  1  serial data driven into chain IN.
REQ-008 scan_in  input  1  serial data returned from chain end.
REQ-009 shift_en  output  1  pass-gate enable, nmos side.
REQ-010 shift_en_n  output  1  pass-gate enable, pmos side.
REQ-011 cap_valid  output  1  one-cycle pulse: cap_data is complete.
REQ-012 cap_data  output  WIDTH  captured word; first bit received lands in bit 0.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHIFT and DONE, plus SETUP when the REQ-029 macro is defined.
REQ-015 shift_en, shift_en_n, scan_out and cap_valid SHALL be driven directly from flops with no combinational output path.
REQ-016 shift_en_n SHALL equal the inverse of shift_en in every cycle, including during reset.
REQ-017 IDLE: load_ready=1, shift_en=0, scan_out=0; a handshake (load_valid & load_ready) SHALL load the tx register, clear the bit counter and go to SHIFT.
REQ-018 SHIFT SHALL last exactly WIDTH cycles, during which shift_en=1 and scan_out=tx[0].
REQ-019 At each rising edge in SHIFT, the block SHALL shift tx right by 1, shift cap right by 1 with scan_in entering at bit WIDTH-1, and increment the counter.
REQ-020 The counter SHALL be ceil(log2(WIDTH+1)) bits wide; SHIFT SHALL exit to DONE when the counter reaches WIDTH-1 at that edge, so the counter never wraps.
REQ-021 Latency SHALL be: handshake in cycle 0 -> shift_en high in cycles 1..WIDTH -> cap_valid=1 in cycle WIDTH+1 (DONE) -> load_ready=1 in cycle WIDTH+2.
REQ-022 DONE SHALL last one cycle with shift_en=0 and load_ready=0, then return to IDLE.
REQ-023 cap_data SHALL hold its value from DONE until the next handshake.
REQ-024 load_valid SHALL be ignored outside IDLE: no buffering and no error.
REQ-025 When load_valid is held high continuously, transfers SHALL proceed back-to-back with exactly one IDLE cycle between DONE and the next SHIFT or SETUP.

Reset
REQ-026 Asserting rst SHALL immediately force IDLE and shift_en=0, shift_en_n=1, scan_out=0, cap_valid=0, cap_data=0, tx=0, counter=0, busy=0; load_ready SHALL be 0 while rst is high.
REQ-027 rst asserted mid-SHIFT SHALL abort the transfer with no cap_valid pulse; the first handshake after release SHALL start a clean transfer.
REQ-028 Release of rst SHALL take effect on the next rising edge, with load_ready=1 from that edge.

Configuration
REQ-029 Macro SHIFT_SETUP_EN: when defined, a handshake SHALL enter SETUP for one cycle (scan_out=load_data[0], shift_en=0), then enter SHIFT; all later latencies shift by +1 (cap_valid in cycle WIDTH+2).
REQ-030 When SHIFT_SETUP_EN is undefined, the SETUP state and its logic SHALL be absent and the timing SHALL follow REQ-021.

Verification
REQ-031 WIDTH=8, scan_in looped to scan_out, load 0xA5 -> scan_out 1,0,1,0,0,1,0,1 in cycles 1..8; cap_valid in cycle 9 with cap_data=0xA5.
REQ-032 WIDTH=8, scan_in tied 1, load 0x00 -> scan_out all 0; cap_data=0xFF; shift_en high exactly 8 cycles.
REQ-033 rst asserted in cycle 4 of SHIFT -> shift_en=0 and shift_en_n=1 in the same cycle, no cap_valid, cap_data=0; the next load 0x3C completes correctly.
REQ-034 load_valid held high, data 0x11 then 0x22 -> two transfers with one IDLE cycle between them; load_valid pulses during SHIFT are ignored.
REQ-035 Every test, every cycle: shift_en_n == ~shift_en; with SHIFT_SETUP_EN defined, re-run REQ-031 -> cap_valid in cycle 10.

Source files
------------

// File: rtl/shift_driver.sv
// shift_driver: loads a parallel word, shifts it LSB-first into a scan chain while capturing the
// returned stream, then pulses cap_valid. Define SHIFT_SETUP_EN to add a one-cycle SETUP state.
module shift_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             scan_out,
    input  logic             scan_in,
    output logic             shift_en,
    output logic             shift_en_n,
    output logic             cap_valid,
    output logic [WIDTH-1:0] cap_data,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_SETUP_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2, ST_SETUP = 2'd3} state_e;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_e;
`endif

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  tx_q, tx_d;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              shift_en_q, shift_en_d;
    logic              shift_en_n_q, shift_en_n_d;
    logic              scan_out_q, scan_out_d;
    logic              cap_valid_q, cap_valid_d;
    logic              load_ready_q, load_ready_d;
    logic              busy_q, busy_d;
    logic              hs_s;
    logic              last_s;

    assign hs_s   = load_valid & load_ready_q;
    assign last_s = (cnt_q == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
`ifdef SHIFT_SETUP_EN
                    state_d = ST_SETUP;
`else
                    state_d = ST_SHIFT;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef SHIFT_SETUP_EN
            ST_SETUP: state_d = ST_SHIFT;
`endif
            ST_SHIFT: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: tx/cap shifters and bit counter
    always_comb begin
        tx_d  = tx_q;
        cap_d = cap_q;
        cnt_d = cnt_q;
        if (hs_s) begin
            tx_d  = load_data;
            cnt_d = {CW{1'b0}};
        end else if (state_q == ST_SHIFT) begin
            tx_d  = tx_q >> 1;
            cap_d = {scan_in, cap_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
        end else begin
            tx_d  = tx_q;
        end
    end

    // Output logic: every output is decoded from the next state so it leaves a flop
    always_comb begin
        shift_en_d   = (state_d == ST_SHIFT);
        shift_en_n_d = ~shift_en_d;
        cap_valid_d  = (state_d == ST_DONE);
        load_ready_d = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        scan_out_d   = 1'b0;
`ifdef SHIFT_SETUP_EN
        if ((state_d == ST_SHIFT) || (state_d == ST_SETUP)) begin
`else
        if (state_d == ST_SHIFT) begin
`endif
            scan_out_d = tx_d[0];
        end else begin
            scan_out_d = 1'b0;
        end
    end

    // Datapath and output registers; reset holds the pass gate off
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q         <= {WIDTH{1'b0}};
            cap_q        <= {WIDTH{1'b0}};
            cnt_q        <= {CW{1'b0}};
            shift_en_q   <= 1'b0;
            shift_en_n_q <= 1'b1;
            scan_out_q   <= 1'b0;
            cap_valid_q  <= 1'b0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            tx_q         <= tx_d;
            cap_q        <= cap_d;
            cnt_q        <= cnt_d;
            shift_en_q   <= shift_en_d;
            shift_en_n_q <= shift_en_n_d;
            scan_out_q   <= scan_out_d;
            cap_valid_q  <= cap_valid_d;
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign shift_en   = shift_en_q;
    assign shift_en_n = shift_en_n_q;
    assign scan_out   = scan_out_q;
    assign cap_valid  = cap_valid_q;
    assign cap_data   = cap_q;
    assign load_ready = load_ready_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_shift_driver.sv
// Scoreboard bench for shift_driver (WIDTH=8); honours SHIFT_SETUP_EN when defined.
module tb_shift_driver;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         scan_out;
    logic         scan_in;
    logic         shift_en;
    logic         shift_en_n;
    logic         cap_valid;
    logic [W-1:0] cap_data;
    logic         busy;

    logic         loop_mode;
    logic         tie_val;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_exp;

    assign scan_in = loop_mode ? scan_out : tie_val;

    always #5 clk = ~clk;

    shift_driver #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .scan_out   (scan_out),
        .scan_in    (scan_in),
        .shift_en   (shift_en),
        .shift_en_n (shift_en_n),
        .cap_valid  (cap_valid),
        .cap_data   (cap_data),
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pair check every cycle, scoreboard pop on each cap_valid
    always @(negedge clk) begin
        checks++;
        if (shift_en_n !== ~shift_en) begin
            errors++;
            $display("FAIL en_pair: shift_en=%b shift_en_n=%b, expected inverse (t=%0t)",
                     shift_en, shift_en_n, $time);
        end
        if (cap_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL cap_unexpected: cap_valid=1 cap_data=%h with no transfer pending (t=%0t)",
                         cap_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                if (cap_data !== mon_exp) begin
                    errors++;
                    $display("FAIL cap_data: got %h, expected %h (t=%0t)", cap_data, mon_exp, $time);
                end
            end
        end
    end

    // Entered at the negedge of the first cycle after the handshake; returns in the IDLE cycle.
    // mode: 0 = load_valid low, 1 = pulse load_valid (must be ignored), 2 = leave load_valid alone
    task automatic shift_phase(input logic [W-1:0] d, input logic [W-1:0] exp, input int mode);
`ifdef SHIFT_SETUP_EN
        chk("setup_shift_en", shift_en, 1'b0);
        chk("setup_scan_out", scan_out, d[0]);
        chk("setup_busy", busy, 1'b1);
        if (mode == 0) load_valid = 1'b0;
        else if (mode == 1) load_valid = 1'b1;
        @(negedge clk);
`endif
        for (int k = 0; k < W; k++) begin
            chk("shift_en", shift_en, 1'b1);
            chk("scan_out", scan_out, d[k]);
            chk("shift_busy", busy, 1'b1);
            chk("shift_ready", load_ready, 1'b0);
            chk("shift_cap_valid", cap_valid, 1'b0);
            if (mode == 0) load_valid = 1'b0;
            else if (mode == 1) load_valid = k[0];
            @(negedge clk);
        end
        chk("done_shift_en", shift_en, 1'b0);
        chk("done_ready", load_ready, 1'b0);
        chk("done_cap_valid", cap_valid, 1'b1);
        chk("done_busy", busy, 1'b1);
        if (mode != 2) load_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", load_ready, 1'b1);
        chk("idle_busy", busy, 1'b0);
        chk("idle_shift_en", shift_en, 1'b0);
        chk("idle_cap_valid", cap_valid, 1'b0);
        chk("idle_scan_out", scan_out, 1'b0);
        chk("cap_hold", cap_data, exp);
    endtask

    task automatic xfer(input logic [W-1:0] d, input logic [W-1:0] exp, input int mode);
        @(negedge clk);
        chk("hs_ready", load_ready, 1'b1);
        chk("hs_shift_en", shift_en, 1'b0);
        load_valid = 1'b1;
        load_data  = d;
        exp_q.push_back(exp);
        @(negedge clk);
        load_valid = 1'b0;
        shift_phase(d, exp, mode);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = 8'h00;
        loop_mode  = 1'b1;
        tie_val    = 1'b0;

        @(negedge clk);
        chk("rst_shift_en", shift_en, 1'b0);
        chk("rst_shift_en_n", shift_en_n, 1'b1);
        chk("rst_scan_out", scan_out, 1'b0);
        chk("rst_cap_valid", cap_valid, 1'b0);
        chk("rst_cap_data", cap_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", load_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("release_ready", load_ready, 1'b1);

        // Loopback returns the word unchanged
        loop_mode = 1'b1;
        xfer(8'hA5, 8'hA5, 0);

        // Chain returns constant 1 / 0
        loop_mode = 1'b0; tie_val = 1'b1;
        xfer(8'h00, 8'hFF, 0);
        tie_val = 1'b0;
        xfer(8'hFF, 8'h00, 0);

        // load_valid pulsing during SHIFT is ignored
        loop_mode = 1'b1;
        xfer(8'h81, 8'h81, 1);
        chk("post_pulse_busy", busy, 1'b0);

        // Back-to-back with load_valid held high
        @(negedge clk);
        chk("b2b_ready", load_ready, 1'b1);
        load_valid = 1'b1;
        load_data  = 8'h11;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        @(negedge clk);
        load_data = 8'h22;
        shift_phase(8'h11, 8'h11, 2);
        @(negedge clk);
        shift_phase(8'h22, 8'h22, 0);

        // Reset in the fourth SHIFT cycle aborts the transfer
        @(negedge clk);
        chk("abort_hs_ready", load_ready, 1'b1);
        load_valid = 1'b1;
        load_data  = 8'h5A;
        @(negedge clk);
        load_valid = 1'b0;
`ifdef SHIFT_SETUP_EN
        @(negedge clk);
`endif
        repeat (3) @(negedge clk);
        chk("abort_pre_shift_en", shift_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_shift_en", shift_en, 1'b0);
        chk("abort_shift_en_n", shift_en_n, 1'b1);
        chk("abort_scan_out", scan_out, 1'b0);
        chk("abort_cap_data", cap_data, 8'h00);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", load_ready, 1'b0);
        chk("abort_cap_valid", cap_valid, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("inrst_ready", load_ready, 1'b0);
            chk("inrst_cap_valid", cap_valid, 1'b0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rerelease_ready", load_ready, 1'b1);
        chk("rerelease_cap_data", cap_data, 8'h00);
        xfer(8'h3C, 8'h3C, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
